// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the test-memory arbiter: FSM states, client ids and access sizes.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE,
        MEM_ARB_ISSUE,
        MEM_ARB_RESP
    } mem_arb_state_t;

    typedef enum logic {
        MEM_ARB_FETCH,
        MEM_ARB_DATA
    } mem_arb_client_t;

    typedef enum logic {
        cpu_data_acc_sz_8  = 1'b0,
        cpu_data_acc_sz_16 = 1'b1
    } cpu_data_acc_sz_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the two CPU client ports and the single test-memory port.
// master = clients plus memory (the environment); slave = the arbiter itself.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_sz;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_sz;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_sz, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_sz, mem_we
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_sz, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_sz, mem_we
    );
endinterface

// File: rtl/mem_access_arbiter_rr_pick.sv
// Two-way round-robin picker; bit 0 is the fetch client, bit 1 the data client.
module mem_arb_rr_pick
    import mem_access_arbiter_pkg::*;
(
    input  logic [1:0]      req,
    input  logic [1:0]      mask,
    input  mem_arb_client_t last_grant,
    output logic            grant_valid,
    output mem_arb_client_t grant
);
    logic [1:0] elig;

    always_comb begin
        elig        = req & ~mask;
        grant_valid = |elig;
        grant       = MEM_ARB_FETCH;
        if (elig == 2'b11) begin
            grant = (last_grant == MEM_ARB_FETCH) ? MEM_ARB_DATA : MEM_ARB_FETCH;
        end else if (elig[1]) begin
            grant = MEM_ARB_DATA;
        end
    end
endmodule

// File: rtl/mem_access_arbiter.sv
// Sole master of the test memory: arbitrates fetch and data clients, one access per 2 cycles.
// state | meaning:  IDLE wait for req | ISSUE mem_* presented, memory samples | RESP rdata valid, ack + re-arbitrate
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_arbiter_if.slave  bus
);
    mem_arb_state_t  state_q, state_d;
    mem_arb_client_t grant_q, last_grant_q, pick_grant;
    logic            pick_valid, load;
    logic [1:0]      pick_mask;
    logic            if_ack, d_ack;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic              mem_sz_q, we_q, wr_q;

    mem_arb_rr_pick u_pick (
        .req         ({bus.d_req, bus.if_req}),
        .mask        (pick_mask),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant       (pick_grant)
    );

    always_comb begin
        state_d   = state_q;
        pick_mask = 2'b00;
        load      = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        case (state_q)
            MEM_ARB_IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_d = MEM_ARB_ISSUE;
                end
            end
            MEM_ARB_ISSUE: state_d = MEM_ARB_RESP;
            MEM_ARB_RESP: begin
                if_ack    = (grant_q == MEM_ARB_FETCH);
                d_ack     = (grant_q == MEM_ARB_DATA);
                // the acked client's req is still the old transaction
                pick_mask = (grant_q == MEM_ARB_FETCH) ? 2'b01 : 2'b10;
                load      = pick_valid;
                state_d   = pick_valid ? MEM_ARB_ISSUE : MEM_ARB_IDLE;
            end
            default: state_d = MEM_ARB_IDLE;
        endcase
        if (reset) begin
            if_ack = 1'b0;
            d_ack  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MEM_ARB_IDLE;
            grant_q      <= MEM_ARB_FETCH;
            last_grant_q <= MEM_ARB_FETCH;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_sz_q     <= cpu_data_acc_sz_16;
            we_q         <= 1'b0;
            wr_q         <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MEM_ARB_ISSUE) we_q <= 1'b0;
            if (if_ack) if_rdata_q <= bus.mem_rdata;
            if (d_ack && !wr_q) d_rdata_q <= bus.mem_rdata;
            if (load) begin
                grant_q      <= pick_grant;
                last_grant_q <= pick_grant;
                if (pick_grant == MEM_ARB_DATA) begin
                    mem_addr_q  <= bus.d_addr;
                    mem_wdata_q <= bus.d_wdata;
                    mem_sz_q    <= bus.d_sz;
                    we_q        <= bus.d_we;
                    wr_q        <= bus.d_we;
                end else begin
                    mem_addr_q  <= bus.if_addr;
                    mem_sz_q    <= cpu_data_acc_sz_16;
                    we_q        <= 1'b0;
                    wr_q        <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_sz    = mem_sz_q;
    assign bus.mem_we    = we_q & ~reset;
    assign bus.if_ack    = if_ack;
    assign bus.d_ack     = d_ack;
    assign bus.if_rdata  = if_ack ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rdata   = (d_ack && !wr_q) ? bus.mem_rdata : d_rdata_q;

    // a granted client must hold its request until its ack
    a_if_hold: assert property (@(posedge clk) disable iff (reset)
        (state_q != MEM_ARB_IDLE && grant_q == MEM_ARB_FETCH) |-> bus.if_req);
    a_d_hold: assert property (@(posedge clk) disable iff (reset)
        (state_q != MEM_ARB_IDLE && grant_q == MEM_ARB_DATA) |-> bus.d_req);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a big-endian byte memory model behind it.
module tb_mem_access_arbiter;
    import mem_access_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_preset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] mem [0:65535];

    mem_access_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_access_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // synchronous memory: write on mem_we, registered read with one cycle latency
    always @(posedge clk) begin
        logic [15:0] a1;
        a1 = bus.mem_addr + 16'd1;
        if (mem_preset) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0010] <= 8'hAB;
            mem[16'h0011] <= 8'hCD;
            mem[16'hFFFF] <= 8'h77;
            mem[16'h0000] <= 8'h88;
            mem[16'h0200] <= 8'hC3;
        end else if (bus.mem_we) begin
            if (bus.mem_sz) begin
                mem[bus.mem_addr] <= bus.mem_wdata[15:8];
                mem[a1]           <= bus.mem_wdata[7:0];
            end else begin
                mem[bus.mem_addr] <= bus.mem_wdata[7:0];
            end
        end
        bus.mem_rdata <= bus.mem_sz ? {mem[bus.mem_addr], mem[a1]} : {8'h00, mem[bus.mem_addr]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at posedge+1 with the arbiter idle; lat = negedge index of d_ack (T = 0)
    task automatic data_xfer(input logic we, input logic sz, input logic [15:0] addr,
                             input logic [15:0] wdata, output int lat, output logic [15:0] rdata,
                             output int we_cnt, output logic [15:0] iss_addr, output logic iss_sz);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_sz = sz; bus.d_addr = addr; bus.d_wdata = wdata;
        lat = -1; we_cnt = 0; rdata = '0; iss_addr = '0; iss_sz = 1'b0;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (i == 1) begin iss_addr = bus.mem_addr; iss_sz = bus.mem_sz; end
            if (bus.d_ack) begin lat = i; rdata = bus.d_rdata; end
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0;
    endtask

    task automatic fetch_xfer(input logic [15:0] addr, output int lat, output logic [15:0] rdata,
                              output int we_cnt);
        bus.if_req = 1'b1; bus.if_addr = addr;
        lat = -1; we_cnt = 0; rdata = '0;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (bus.if_ack) begin lat = i; rdata = bus.if_rdata; end
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int          lat, we_cnt, n;
        logic [15:0] rd, iss_addr;
        logic        iss_sz;
        int          ack_cyc [3];
        logic [15:0] ack_dat [3];
        logic [15:0] t6_addr [3];
        logic        t6_sz [3];
        logic [1:0]  exp_acks;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_sz = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (2) @(posedge clk);
        #1 mem_preset = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_mem_sz", 32'(bus.mem_sz), 32'd1);
        chk("rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // fetch of 0x0010
        fetch_xfer(16'h0010, lat, rd, we_cnt);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_rdata", 32'(rd), 32'hABCD);
        chk("t1_we", 32'(we_cnt), 32'd0);

        // 16-bit read at the top of the address range
        data_xfer(1'b0, 1'b1, 16'hFFFF, 16'h0, lat, rd, we_cnt, iss_addr, iss_sz);
        chk("t4_lat", 32'(lat), 32'd2);
        chk("t4_addr", 32'(iss_addr), 32'hFFFF);
        chk("t4_sz", 32'(iss_sz), 32'd1);
        chk("t4_rdata", 32'(rd), 32'h7788);

        // write then byte read-back; d_rdata must hold across the write ack
        data_xfer(1'b1, 1'b1, 16'h0101, 16'h1234, lat, rd, we_cnt, iss_addr, iss_sz);
        chk("t2w_lat", 32'(lat), 32'd2);
        chk("t2w_we_cycles", 32'(we_cnt), 32'd1);
        chk("t2w_rdata_hold", 32'(rd), 32'h7788);
        data_xfer(1'b0, 1'b0, 16'h0102, 16'h0, lat, rd, we_cnt, iss_addr, iss_sz);
        chk("t2r_lat", 32'(lat), 32'd2);
        chk("t2r_rdata", 32'(rd), 32'h0034);
        chk("t2r_we", 32'(we_cnt), 32'd0);
        chk("t2r_if_hold", 32'(bus.if_rdata), 32'hABCD);

        // both clients held from reset: DATA first, then alternate every 2 cycles
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_sz = 1'b1; bus.d_addr = 16'h0101;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            exp_acks = (i == 2 || i == 6) ? 2'b01 : (i == 4 || i == 8) ? 2'b10 : 2'b00;
            chk($sformatf("t3_acks_c%0d", i), 32'({bus.if_ack, bus.d_ack}), 32'(exp_acks));
            if (i == 2) chk("t3_d_rdata", 32'(bus.d_rdata), 32'h1234);
            if (i == 4) chk("t3_if_rdata", 32'(bus.if_rdata), 32'hABCD);
            @(posedge clk); #1;
            if (i == 6) bus.d_req = 1'b0;
            if (i == 8) bus.if_req = 1'b0;
        end

        // data held for 3 reads; a lone client is masked in RESP and re-enters via IDLE
        t6_addr[0] = 16'h0010; t6_sz[0] = 1'b1;
        t6_addr[1] = 16'h0101; t6_sz[1] = 1'b1;
        t6_addr[2] = 16'h0102; t6_sz[2] = 1'b0;
        n = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = t6_addr[0]; bus.d_sz = t6_sz[0];
        for (int i = 0; i < 15; i++) begin
            logic acked;
            @(negedge clk);
            acked = bus.d_ack;
            if (acked && n < 3) begin ack_cyc[n] = i; ack_dat[n] = bus.d_rdata; end
            if (acked) n++;
            @(posedge clk); #1;
            if (acked && n >= 3) bus.d_req = 1'b0;
            else if (acked) begin bus.d_addr = t6_addr[n]; bus.d_sz = t6_sz[n]; end
        end
        chk("t6_count", 32'(n), 32'd3);
        chk("t6_cyc0", 32'(ack_cyc[0]), 32'd2);
        chk("t6_cyc1", 32'(ack_cyc[1]), 32'd5);
        chk("t6_cyc2", 32'(ack_cyc[2]), 32'd8);
        chk("t6_dat0", 32'(ack_dat[0]), 32'hABCD);
        chk("t6_dat1", 32'(ack_dat[1]), 32'h1234);
        chk("t6_dat2", 32'(ack_dat[2]), 32'h0034);

        // reset during a write ISSUE cycle suppresses the write and the ack
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_sz = 1'b0; bus.d_addr = 16'h0200; bus.d_wdata = 16'h005A;
        @(negedge clk);
        chk("t5_ack_idle", 32'(bus.d_ack), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_issue_addr", 32'(bus.mem_addr), 32'h0200);
        chk("t5_we_gated", 32'(bus.mem_we), 32'd0);
        chk("t5_ack_issue", 32'(bus.d_ack), 32'd0);
        @(posedge clk); #1;
        bus.d_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("t5_state", 32'(dut.state_q), 32'(MEM_ARB_IDLE));
        chk("t5_ack_after", 32'(bus.d_ack), 32'd0);
        repeat (2) @(negedge clk);
        chk("t5_ack_late", 32'(bus.d_ack), 32'd0);
        chk("t5_mem", 32'(mem[16'h0200]), 32'h00C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
